// File: rtl/conv_1d_ctrl.sv
// Frame sequencer and credit-based flow controller wrapped around the conv_1d core.
// Define CONV_1D_CTRL_STATS_EN to add the frame_cnt/short_cnt statistics outputs.
module conv_1d_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int KERNEL_SIZE   = 8,
    parameter int CORE_LATENCY  = 3,
    parameter int FIFO_DEPTH    = 8,
    localparam int RESULT_WIDTH = 2*DATA_WIDTH + $clog2(KERNEL_SIZE)
) (
    input  logic                              clk,
    input  logic                              arst_n,
    input  logic [DATA_WIDTH-1:0]             in_data,
    input  logic                              in_vld,
    input  logic                              in_last,
    output logic                              in_rdy,
    input  logic                              kcfg_wr,
    input  logic [$clog2(KERNEL_SIZE)-1:0]    kcfg_idx,
    input  logic [DATA_WIDTH-1:0]             kcfg_data,
    input  logic                              kcfg_commit,
    output logic                              kcfg_pending,
    output logic [DATA_WIDTH-1:0]             core_signal_data,
    output logic                              core_signal_vld,
    output logic [KERNEL_SIZE*DATA_WIDTH-1:0] core_kernel,
    input  logic [RESULT_WIDTH-1:0]           core_result_data,
    input  logic                              core_result_vld,
    output logic [RESULT_WIDTH-1:0]           out_data,
    output logic                              out_vld,
    output logic                              out_last,
    input  logic                              out_rdy,
    output logic                              short_frame
`ifdef CONV_1D_CTRL_STATS_EN
    ,
    output logic [15:0]                       frame_cnt,
    output logic [15:0]                       short_cnt
`endif
);

    localparam int IDX_W  = $clog2(KERNEL_SIZE);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_W1 = CNT_W + 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int GRD_W  = $clog2(CORE_LATENCY + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(KERNEL_SIZE - 1);
    localparam logic [CNT_W:0]    DEPTH_C  = CNT_W1'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                   state_q, state_d;
    logic                     pending_q, pending_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]         inflight_q, inflight_d;
    logic [CNT_W-1:0]         fifoCount_q, fifoCount_d;
    logic [PTR_W-1:0]         wrPtr_q, rdPtr_q;
    logic [DATA_WIDTH-1:0]    shadow_q [KERNEL_SIZE];
    logic [DATA_WIDTH-1:0]    active_q [KERNEL_SIZE];
    logic [DATA_WIDTH-1:0]    issueData_q;
    logic                     issueVld_q, issueKeep_q, issueLast_q;
    logic [CORE_LATENCY-1:0]  tagVld_q, tagKeep_q, tagLast_q;
    logic                     rdyEn_q;
    logic [GRD_W-1:0]         guard_q;
    logic [RESULT_WIDTH:0]    mem_q [FIFO_DEPTH];

    logic freeOk, accept, keep, swap, tagPop, push, pop;

    function automatic logic [PTR_W-1:0] ptrNext(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Warm-up samples and retired-but-discarded tags still hold a credit until they exit.
    assign freeOk = ({1'b0, fifoCount_q} + {1'b0, inflight_q}) < DEPTH_C;
    assign in_rdy = rdyEn_q && freeOk && ((state_q == RUN) || (state_q == IDLE && !pending_q));
    assign accept = in_vld && in_rdy;
    assign keep   = (idx_q >= LAST_IDX);
    assign tagPop = tagVld_q[CORE_LATENCY-1];
    assign push   = tagPop && tagKeep_q[CORE_LATENCY-1];
    assign out_vld  = (fifoCount_q != '0);
    assign pop      = out_vld && out_rdy;
    assign out_data = mem_q[rdPtr_q][RESULT_WIDTH-1:0];
    assign out_last = out_vld && mem_q[rdPtr_q][RESULT_WIDTH];

    assign short_frame      = accept && in_last && !keep;
    assign kcfg_pending     = pending_q;
    assign core_signal_data = issueData_q;
    assign core_signal_vld  = issueVld_q;

    for (genvar g = 0; g < KERNEL_SIZE; g++) begin : gKernel
        assign core_kernel[g*DATA_WIDTH +: DATA_WIDTH] = active_q[g];
    end

    always_comb begin
        state_d     = state_q;
        swap        = 1'b0;
        idx_d       = idx_q;
        inflight_d  = inflight_q;
        fifoCount_d = fifoCount_q;
        case (state_q)
            IDLE: begin
                if (pending_q) swap = 1'b1;
                else if (accept) state_d = in_last ? DRAIN : RUN;
            end
            RUN:     if (accept && in_last) state_d = DRAIN;
            DRAIN:   if (inflight_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        pending_d = kcfg_commit || (pending_q && !swap);
        if (accept) idx_d = in_last ? '0 : (keep ? idx_q : idx_q + IDX_W'(1));
        case ({accept, tagPop})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
        case ({push, pop})
            2'b10:   fifoCount_d = fifoCount_q + CNT_W'(1);
            2'b01:   fifoCount_d = fifoCount_q - CNT_W'(1);
            default: fifoCount_d = fifoCount_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q     <= IDLE;
            pending_q   <= 1'b0;
            idx_q       <= '0;
            inflight_q  <= '0;
            fifoCount_q <= '0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            issueData_q <= '0;
            issueVld_q  <= 1'b0;
            issueKeep_q <= 1'b0;
            issueLast_q <= 1'b0;
            tagVld_q    <= '0;
            tagKeep_q   <= '0;
            tagLast_q   <= '0;
            rdyEn_q     <= 1'b0;
            guard_q     <= GRD_W'(CORE_LATENCY);
            for (int k = 0; k < KERNEL_SIZE; k++) begin
                shadow_q[k] <= '0;
                active_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            idx_q       <= idx_d;
            inflight_q  <= inflight_d;
            fifoCount_q <= fifoCount_d;
            rdyEn_q     <= 1'b1;
            if (guard_q != '0) guard_q <= guard_q - GRD_W'(1);
            issueVld_q <= accept;
            if (accept) begin
                issueData_q <= in_data;
                issueKeep_q <= keep;
                issueLast_q <= in_last && keep;
            end
            tagVld_q[0]  <= issueVld_q;
            tagKeep_q[0] <= issueKeep_q;
            tagLast_q[0] <= issueLast_q;
            for (int i = 1; i < CORE_LATENCY; i++) begin
                tagVld_q[i]  <= tagVld_q[i-1];
                tagKeep_q[i] <= tagKeep_q[i-1];
                tagLast_q[i] <= tagLast_q[i-1];
            end
            if (kcfg_wr) shadow_q[kcfg_idx] <= kcfg_data;
            if (swap) begin
                for (int k = 0; k < KERNEL_SIZE; k++) active_q[k] <= shadow_q[k];
            end
            if (push) wrPtr_q <= ptrNext(wrPtr_q);
            if (pop)  rdPtr_q <= ptrNext(rdPtr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wrPtr_q] <= {tagLast_q[CORE_LATENCY-1], core_result_data};
    end

    // The core is not reset with us, so results still in its pipe at reset are tolerated.
    always_ff @(posedge clk) begin
        if (arst_n && guard_q == '0) assert (core_result_vld == tagPop);
        if (arst_n) assert (!(push && fifoCount_q == CNT_W'(FIFO_DEPTH)));
    end

`ifdef CONV_1D_CTRL_STATS_EN
    logic [15:0] frameCnt_q, shortCnt_q;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            frameCnt_q <= '0;
            shortCnt_q <= '0;
        end else begin
            if (state_q == DRAIN && state_d == IDLE && frameCnt_q != 16'hFFFF)
                frameCnt_q <= frameCnt_q + 16'd1;
            if (short_frame && shortCnt_q != 16'hFFFF)
                shortCnt_q <= shortCnt_q + 16'd1;
        end
    end

    assign frame_cnt = frameCnt_q;
    assign short_cnt = shortCnt_q;
`endif

endmodule

// File: tb/tb_conv_1d_ctrl.sv
// Self-checking bench for conv_1d_ctrl with a behavioural conv_1d core and an output scoreboard.
// Checks the statistics outputs when CONV_1D_CTRL_STATS_EN is defined.
module tb_conv_1d_ctrl;

    localparam int DW = 8;
    localparam int K  = 8;
    localparam int L  = 3;
    localparam int FD = 8;
    localparam int RW = 2*DW + $clog2(K);

    logic              clk = 1'b0;
    logic              arst_n = 1'b0;
    logic [DW-1:0]     in_data = '0;
    logic              in_vld = 1'b0;
    logic              in_last = 1'b0;
    logic              in_rdy;
    logic              kcfg_wr = 1'b0;
    logic [$clog2(K)-1:0] kcfg_idx = '0;
    logic [DW-1:0]     kcfg_data = '0;
    logic              kcfg_commit = 1'b0;
    logic              kcfg_pending;
    logic [DW-1:0]     core_signal_data;
    logic              core_signal_vld;
    logic [K*DW-1:0]   core_kernel;
    logic [RW-1:0]     core_result_data;
    logic              core_result_vld;
    logic [RW-1:0]     out_data;
    logic              out_vld;
    logic              out_last;
    logic              out_rdy = 1'b0;
    logic              short_frame;
`ifdef CONV_1D_CTRL_STATS_EN
    logic [15:0]       frame_cnt;
    logic [15:0]       short_cnt;
`endif

    conv_1d_ctrl #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .CORE_LATENCY(L), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .arst_n(arst_n),
        .in_data(in_data), .in_vld(in_vld), .in_last(in_last), .in_rdy(in_rdy),
        .kcfg_wr(kcfg_wr), .kcfg_idx(kcfg_idx), .kcfg_data(kcfg_data),
        .kcfg_commit(kcfg_commit), .kcfg_pending(kcfg_pending),
        .core_signal_data(core_signal_data), .core_signal_vld(core_signal_vld),
        .core_kernel(core_kernel),
        .core_result_data(core_result_data), .core_result_vld(core_result_vld),
        .out_data(out_data), .out_vld(out_vld), .out_last(out_last), .out_rdy(out_rdy),
        .short_frame(short_frame)
`ifdef CONV_1D_CTRL_STATS_EN
        , .frame_cnt(frame_cnt), .short_cnt(short_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // Behavioural conv_1d core: sliding window, newest sample on tap 0, fixed latency, no reset.
    logic [DW-1:0] coreWin [K] = '{default: '0};
    logic [RW-1:0] corePipeData [L] = '{default: '0};
    logic          corePipeVld [L] = '{default: 1'b0};
    logic [RW-1:0] coreAcc;

    always_comb begin
        coreAcc = RW'(core_signal_data) * RW'(core_kernel[DW-1:0]);
        for (int i = 1; i < K; i++)
            coreAcc = coreAcc + RW'(coreWin[i-1]) * RW'(core_kernel[i*DW +: DW]);
    end

    always @(posedge clk) begin
        if (core_signal_vld) begin
            coreWin[0] <= core_signal_data;
            for (int i = 1; i < K; i++) coreWin[i] <= coreWin[i-1];
        end
        corePipeVld[0]  <= core_signal_vld;
        corePipeData[0] <= coreAcc;
        for (int i = 1; i < L; i++) begin
            corePipeVld[i]  <= corePipeVld[i-1];
            corePipeData[i] <= corePipeData[i-1];
        end
    end

    assign core_result_vld  = corePipeVld[L-1];
    assign core_result_data = corePipeData[L-1];

    int total = 0;
    int bad = 0;
    logic [RW:0] expQ [$];
    int frameSamples [$];
    int frameCoef = 1;
    int acceptCount = 0;
    int outCount = 0;
    int shortPulses = 0;
    int firstVld = -1;
    int keepStartCycle = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Output monitor: scoreboard pops on every handshake, sampled mid-cycle.
    initial begin
        logic [RW:0] exp;
        forever begin
            @(negedge clk);
            if (arst_n) begin
                if (short_frame) shortPulses++;
                if (out_vld && firstVld < 0) firstVld = cycle;
                if (out_vld && out_rdy) begin
                    outCount++;
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_out", 32'(out_vld), 32'd0);
                    end else begin
                        exp = expQ.pop_front();
                        checkOutput("out_data", 32'(out_data), 32'(exp[RW-1:0]));
                        checkOutput("out_last", 32'(out_last), 32'(exp[RW]));
                    end
                end
            end
        end
    end

    task automatic sendSample(input logic [DW-1:0] d, input logic last);
        int waitCnt;
        int idx;
        int s;
        bit ok;
        waitCnt = 0;
        ok = 1'b0;
        in_data = d;
        in_last = last;
        in_vld  = 1'b1;
        while (!ok && waitCnt < 500) begin
            @(negedge clk);
            if (in_rdy) begin
                ok = 1'b1;
                idx = frameSamples.size();
                checkOutput("short_frame", 32'(short_frame), 32'(last && idx < K-1));
                acceptCount++;
                if (idx == K-1) keepStartCycle = cycle;
                frameSamples.push_back(int'(d));
                if (frameSamples.size() >= K) begin
                    s = 0;
                    for (int j = frameSamples.size() - K; j < frameSamples.size(); j++)
                        s += frameSamples[j];
                    expQ.push_back({last, RW'(s * frameCoef)});
                end
                if (last) frameSamples.delete();
            end else begin
                waitCnt++;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) checkOutput("accept_timeout", 32'(waitCnt), 32'd0);
    endtask

    task automatic applyStimulus(input int first, input int n, input int coef, input bit endFrame);
        if (frameSamples.size() == 0) frameCoef = coef;
        for (int i = 0; i < n; i++)
            sendSample(DW'(first + i), endFrame && (i == n-1));
        in_vld  = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic writeKernel(input logic [DW-1:0] coef);
        for (int k = 0; k < K; k++) begin
            kcfg_wr     = 1'b1;
            kcfg_idx    = k[$clog2(K)-1:0];
            kcfg_data   = coef;
            kcfg_commit = (k == K-1);
            @(posedge clk);
            #1;
        end
        kcfg_wr     = 1'b0;
        kcfg_commit = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        checkOutput("drain_timeout", 32'(expQ.size()), 32'd0);
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int outBase;
        int shortBase;
        int staleVld;
        logic lastRdy;

        $display("[TB] reset");
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_rdy", 32'(in_rdy), 32'd0);
        checkOutput("rst_core_vld", 32'(core_signal_vld), 32'd0);
        checkOutput("rst_out_vld", 32'(out_vld), 32'd0);
        checkOutput("rst_out_last", 32'(out_last), 32'd0);
        checkOutput("rst_short", 32'(short_frame), 32'd0);
        checkOutput("rst_pending", 32'(kcfg_pending), 32'd0);
        @(posedge clk);
        #1;
        arst_n = 1'b1;

        $display("[TB] kernel all 1s, frame 1..10");
        writeKernel(8'd1);
        @(negedge clk);
        checkOutput("swap_pending", 32'(kcfg_pending), 32'd1);
        checkOutput("swap_in_rdy", 32'(in_rdy), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("post_swap_pending", 32'(kcfg_pending), 32'd0);
        checkOutput("post_swap_in_rdy", 32'(in_rdy), 32'd1);
        @(posedge clk);
        #1;
        out_rdy = 1'b1;
        firstVld = -1;
        outBase = outCount;
        applyStimulus(1, 10, 1, 1'b1);
        waitDrain();
        checkOutput("frame1_count", 32'(outCount - outBase), 32'd3);
        checkOutput("first_latency", 32'(firstVld - keepStartCycle), 32'd5);

        $display("[TB] backpressure, 20-sample frame");
        out_rdy = 1'b0;
        base = acceptCount;
        outBase = outCount;
        fork
            applyStimulus(1, 20, 1, 1'b1);
            begin
                repeat (40) @(posedge clk);
                @(negedge clk);
                checkOutput("bp_accepted", 32'(acceptCount - base), 32'd15);
                checkOutput("bp_in_rdy", 32'(in_rdy), 32'd0);
                checkOutput("bp_out_vld", 32'(out_vld), 32'd1);
                @(posedge clk);
                #1;
                out_rdy = 1'b1;
            end
        join
        waitDrain();
        checkOutput("bp_out_count", 32'(outCount - outBase), 32'd13);

        $display("[TB] short frame");
        outBase = outCount;
        shortBase = shortPulses;
        applyStimulus(1, 5, 1, 1'b1);
        waitDrain();
        checkOutput("short_no_out", 32'(outCount - outBase), 32'd0);
        checkOutput("short_pulses", 32'(shortPulses - shortBase), 32'd1);
        @(negedge clk);
        checkOutput("short_idle_rdy", 32'(in_rdy), 32'd1);
        @(posedge clk);
        #1;
        applyStimulus(11, 8, 1, 1'b1);
        waitDrain();
        checkOutput("after_short_count", 32'(outCount - outBase), 32'd1);

        $display("[TB] commit mid-frame");
        outBase = outCount;
        applyStimulus(1, 4, 1, 1'b0);
        writeKernel(8'd2);
        @(negedge clk);
        checkOutput("mid_pending", 32'(kcfg_pending), 32'd1);
        @(posedge clk);
        #1;
        applyStimulus(5, 6, 1, 1'b1);
        @(negedge clk);
        checkOutput("drain_pending", 32'(kcfg_pending), 32'd1);
        lastRdy = 1'b1;
        for (int n = 0; n < 100 && kcfg_pending; n++) begin
            lastRdy = in_rdy;
            @(negedge clk);
        end
        checkOutput("pending_cleared", 32'(kcfg_pending), 32'd0);
        checkOutput("swap_cycle_rdy", 32'(lastRdy), 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(1, 8, 2, 1'b1);
        waitDrain();
        checkOutput("commit_out_count", 32'(outCount - outBase), 32'd4);

        $display("[TB] reset mid-frame");
        applyStimulus(1, 9, 2, 1'b0);
        arst_n = 1'b0;
        expQ.delete();
        frameSamples.delete();
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_in_rdy", 32'(in_rdy), 32'd0);
        checkOutput("mid_rst_core_vld", 32'(core_signal_vld), 32'd0);
        checkOutput("mid_rst_out_vld", 32'(out_vld), 32'd0);
        checkOutput("mid_rst_out_last", 32'(out_last), 32'd0);
        checkOutput("mid_rst_pending", 32'(kcfg_pending), 32'd0);
        staleVld = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_vld) staleVld++;
        end
        checkOutput("stale_out_vld", 32'(staleVld), 32'd0);
        @(posedge clk);
        #1;
        outBase = outCount;
        writeKernel(8'd1);
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(1, 8, 1, 1'b1);
        waitDrain();
        checkOutput("post_rst_count", 32'(outCount - outBase), 32'd1);

        $display("[TB] frame statistics sequence");
        applyStimulus(3, 8, 1, 1'b1);
        applyStimulus(7, 9, 1, 1'b1);
        applyStimulus(1, 3, 1, 1'b1);
        applyStimulus(20, 2, 1, 1'b1);
        waitDrain();
`ifdef CONV_1D_CTRL_STATS_EN
        checkOutput("frame_cnt", 32'(frame_cnt), 32'd5);
        checkOutput("short_cnt", 32'(short_cnt), 32'd2);
`endif
        checkOutput("final_out_vld", 32'(out_vld), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_1d_ctrl.md
Name: conv_1d_ctrl

Overview:
Frame sequencer and flow controller wrapped around the conv_1d convolution core.
- Accepts framed sample streams from upstream and issues them to the core.
- Owns the kernel registers, with a shadow copy swapped only between frames.
- The core has no backpressure, so this block adds it: credit-based issue into an output FIFO.
- Discards the KERNEL_SIZE-1 warm-up results of each frame and tags the last result of each frame.

Parameters:
DATA_WIDTH, 8, sample and kernel coefficient width
KERNEL_SIZE, 8, number of kernel taps (>=2)
CORE_LATENCY, 3, cycles from core_signal_vld to core_result_vld
FIFO_DEPTH, 8, output FIFO entries (>=1)
RESULT_WIDTH (localparam), 2*DATA_WIDTH+$clog2(KERNEL_SIZE)

Ports:
clk  in  1  clock
arst_n  in  1  synchronous active-low reset; the name is kept for codebase consistency, but it is sampled on posedge clk only
in_data  in  DATA_WIDTH  upstream sample
in_vld  in  1  upstream valid
in_last  in  1  last sample of frame
in_rdy  out  1  upstream ready
kcfg_wr  in  1  write kcfg_data into shadow[kcfg_idx]
kcfg_idx  in  $clog2(KERNEL_SIZE)  shadow tap index
kcfg_data  in  DATA_WIDTH  coefficient
kcfg_commit  in  1  request shadow->active swap
kcfg_pending  out  1  swap requested, not yet applied
core_signal_data  out  DATA_WIDTH  to core signal_data
core_signal_vld  out  1  to core signal_vld
core_kernel  out  KERNEL_SIZE*DATA_WIDTH  active kernel to core
core_result_data  in  RESULT_WIDTH  from core
core_result_vld  in  1  from core
out_data  out  RESULT_WIDTH  result
out_vld  out  1  result valid
out_last  out  1  last result of frame
out_rdy  in  1  downstream ready
short_frame  out  1  one-cycle pulse: a frame shorter than KERNEL_SIZE ended

Behaviour:
Reset values:
- in_rdy=0, core_signal_vld=0, out_vld=0, out_last=0, short_frame=0, kcfg_pending=0.
- Shadow and active kernels = 0; FIFO empty; state=IDLE; all counters 0.
- Reset mid-frame discards in-flight tags and FIFO contents. Core results that arrive after reset are ignored, because the tag pipeline is empty.

FSM states: IDLE (between frames), RUN (frame open), DRAIN (last sample issued; waiting for the tag pipeline to empty).
- IDLE: if kcfg_pending, copy shadow to active, clear kcfg_pending, hold in_rdy=0 for that cycle. Otherwise an accepted sample goes to RUN, or to DRAIN if in_last.
- RUN: an accepted sample with in_last goes to DRAIN.
- DRAIN: in_rdy=0; go to IDLE when no tags are in flight.

Credits:
- free = FIFO_DEPTH - fifo_count - inflight.
- in_rdy = (state IDLE or RUN) && free>0 && !(IDLE && kcfg_pending).
- Accept = in_vld && in_rdy. Each accept increments inflight; each tag pop decrements it.

Issue:
- Accepted data is registered: core_signal_data/core_signal_vld are driven one cycle after accept.
- core_signal_vld pulses once per accepted sample.

Tags:
- A CORE_LATENCY-deep shift register carries {vld, keep, last} aligned with the core.
- keep = (per-frame sample index >= KERNEL_SIZE-1).
- last = in_last && keep.
- When the tag exits with vld: keep=1 pushes {core_result_data, last} into the FIFO; keep=0 discards the result.
- core_result_vld must equal the exiting tag vld; a mismatch is a simulation assertion error.

Frame rules:
- The sample index resets to 0 after each in_last.
- A frame of fewer than KERNEL_SIZE samples produces no results; short_frame pulses on the cycle its last sample is accepted.

Output FIFO:
- First-word-fall-through: out_vld=!empty, head on out_data/out_last, pop on out_vld&&out_rdy.
- Push and pop in the same cycle are allowed.
- Credits guarantee no push when full; a push when full is an assertion error.

Latency: accept at cycle t -> core_signal_vld at t+1 -> FIFO push at t+1+CORE_LATENCY -> out_vld at t+2+CORE_LATENCY (t+5 with defaults).

Kernel config:
- kcfg_wr is always accepted into the shadow, including while a swap is pending.
- A write in the same cycle as kcfg_commit is included in the swap.
- The active kernel never changes while state is RUN or DRAIN.

Optional Feature:
CONV_1D_CTRL_STATS_EN:
- Defined: adds outputs frame_cnt[15:0] (frames completed, +1 on each DRAIN->IDLE) and short_cnt[15:0] (+1 per short_frame pulse). Both saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Kernel all 1s committed; frame 1..10, out_rdy=1 -> three outputs 36, 44, 52; out_last only on 52; first out_vld 5 cycles after the 8th accept.
- out_rdy=0, 20-sample frame -> exactly 15 samples accepted, then in_rdy=0 with 8 FIFO entries; raising out_rdy drains and the remaining samples resume.
- 5-sample frame with in_last -> no out_vld, short_frame one pulse, FSM returns to IDLE; the next 8-sample frame yields exactly one output.
- kcfg_commit mid-frame with new kernel all 2s -> current frame results use the all-1s kernel; kcfg_pending=1 until the IDLE swap cycle (in_rdy=0 there); the next frame 1..8 gives 72.
- arst_n low for 1 cycle mid-frame with in-flight samples -> all outputs at reset values, no stale out_vld; the following frame is correct.
- With CONV_1D_CTRL_STATS_EN: 3 normal frames + 2 short frames -> frame_cnt=5, short_cnt=2.
